// File: rtl/uart_cmd_bridge_pkg.sv
// Shared protocol constants and state encoding for the UART command bridge.
// Host-side test code can import this package to build command streams.
package uart_cmd_bridge_pkg;

  // Command opcodes ('W' and 'R' in ASCII)
  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;

  // Default response bytes (ASCII ACK / NAK)
  localparam logic [7:0] AckByteDefault = 8'h06;
  localparam logic [7:0] NakByteDefault = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StData,
    StMem,
    StResp
  } state_e;

  // True for the two opcodes the bridge understands
  function automatic logic is_known_op(logic [7:0] op);
    return (op == OpWrite) || (op == OpRead);
  endfunction

endpackage

// File: rtl/uart_cmd_bridge.sv
// Host-side command engine: pops command bytes from the UART RX FIFO, performs one
// memory-bus access and pushes a single response byte into the UART TX FIFO.
module uart_cmd_bridge
  import uart_cmd_bridge_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE = AckByteDefault,
  parameter logic [7:0] NAK_BYTE = NakByteDefault
) (
  input  logic        clk,
  input  logic        reset,
  // UART RX FIFO side
  input  logic        rx_empty,
  input  logic [7:0]  r_data,
  output logic        rd_uart,
  // UART TX FIFO side
  input  logic        tx_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  // Memory bus
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  // Status
  output logic        busy
);

  state_e      state_q, state_d;
  logic [15:0] addr_q,  addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q,    we_d;
  logic        req_q,   req_d;
  logic [7:0]  resp_q,  resp_d;

  logic byte_state;

  // Strobes are decoded from the registered state so a pop/push lines up with the
  // edge that captures the byte or leaves RESP; both are forced low during reset.
  always_comb begin
    byte_state = (state_q == StIdle)   || (state_q == StAddrHi) ||
                 (state_q == StAddrLo) || (state_q == StData);
    rd_uart    = byte_state && !rx_empty && !reset;
    wr_uart    = (state_q == StResp) && !tx_full && !reset;
    busy       = (state_q != StIdle);
  end

  // Next-state: consume at most one RX byte per cycle, then access, then respond
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    req_d   = req_q;
    resp_d  = resp_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_empty) begin
          if (is_known_op(r_data)) begin
            we_d    = (r_data == OpWrite);
            state_d = StAddrHi;
          end else begin
            resp_d  = NAK_BYTE;
            state_d = StResp;
          end
        end
      end
      StAddrHi: begin
        if (!rx_empty) begin
          addr_d[15:8] = r_data;
          state_d      = StAddrLo;
        end
      end
      StAddrLo: begin
        if (!rx_empty) begin
          addr_d[7:0] = r_data;
          if (we_q) begin
            state_d = StData;
          end else begin
            // Request is raised on entry so it is visible in the first MEM cycle
            req_d   = 1'b1;
            state_d = StMem;
          end
        end
      end
      StData: begin
        if (!rx_empty) begin
          wdata_d = r_data;
          req_d   = 1'b1;
          state_d = StMem;
        end
      end
      StMem: begin
        if (req_q && mem_ack) begin
          req_d   = 1'b0;
          resp_d  = we_q ? ACK_BYTE : mem_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        if (!tx_full) begin
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset aborts any command or access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      resp_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_req   = req_q;
  assign w_data    = resp_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: directed vector table, hand-written corner
// sequences and a randomized command stream checked against a transaction-level model.
module tb_uart_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        tx_full;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy;

  uart_cmd_bridge #(
    .ACK_BYTE(8'h06),
    .NAK_BYTE(8'h15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .w_data   (w_data),
    .wr_uart  (wr_uart),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          cyc;
  } acc_t;

  typedef struct {
    int          nb;
    logic [31:0] b;
    int          lat;
    bit          pre_en;
    logic [15:0] pre_addr;
    logic [7:0]  pre_val;
    bit          exp_acc;
    bit          exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    int          exp_cyc;
    logic [7:0]  exp_tx;
  } vec_t;

  int         n_cmp;
  int         n_bad;
  logic [7:0] rx_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] tx_log[$];
  acc_t       acc_log[$];
  logic [7:0] resp_mem[65536];
  logic [7:0] model_mem[65536];
  int         ack_lat;
  int         req_cnt;
  bit         rand_lat, spur_en, ack_force, feed_en, rand_full;
  bit         prev_wr;
  logic [15:0] hold_addr;
  logic [7:0]  hold_wdata;
  logic        hold_we;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] init_byte(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic drive_rx();
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'($urandom) : rx_q[0];
  endtask

  task automatic clear_logs();
    tx_log.delete();
    acc_log.delete();
  endtask

  // One clock: sample at negedge, then update environment 1 time unit after posedge
  task automatic step();
    bit pop;
    @(negedge clk);
    pop = 1'b0;
    check("rd_wr_overlap", 32'(rd_uart & wr_uart), 32'd0);
    if (rd_uart) begin
      check("rd_when_empty", 32'(rx_empty), 32'd0);
      pop = 1'b1;
    end
    if (mem_req) begin
      check("rd_during_mem", 32'(rd_uart), 32'd0);
      check("addr_stable", 32'(mem_addr), 32'(hold_addr));
      check("we_stable", 32'(mem_we), 32'(hold_we));
      check("wdata_stable", 32'(mem_wdata), 32'(hold_wdata));
    end
    if (wr_uart) begin
      check("wr_back_to_back", 32'(prev_wr), 32'd0);
      tx_log.push_back(w_data);
    end
    prev_wr = wr_uart;
    if (mem_req && mem_ack) begin
      acc_log.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata, cyc: req_cnt});
      if (mem_we) resp_mem[mem_addr] = mem_wdata;
    end
    @(posedge clk);
    #1;
    if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
    if (feed_en && pend_q.size() > 0 && $urandom_range(0, 2) != 0)
      rx_q.push_back(pend_q.pop_front());
    drive_rx();
    if (mem_req) begin
      req_cnt++;
      if (req_cnt == 1) begin
        hold_addr  = mem_addr;
        hold_we    = mem_we;
        hold_wdata = mem_wdata;
        if (rand_lat) ack_lat = $urandom_range(1, 4);
      end
    end else begin
      req_cnt = 0;
    end
    if (ack_force)    mem_ack = 1'b1;
    else if (mem_req) mem_ack = (req_cnt >= ack_lat);
    else              mem_ack = spur_en && ($urandom_range(0, 3) == 0);
    mem_rdata = resp_mem[mem_addr];
    if (rand_full) tx_full = ($urandom_range(0, 9) < 3);
  endtask

  task automatic run_until_tx(int n, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (tx_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  vec_t       vec[7];
  acc_t       exp_acc[$];
  logic [7:0] exp_tx[$];

  initial begin
    bit ok;
    int wr_at;
    int kind;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  op;

    n_cmp = 0; n_bad = 0;
    reset = 1'b1; tx_full = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    ack_lat = 1; req_cnt = 0; prev_wr = 1'b0;
    rand_lat = 0; spur_en = 0; ack_force = 0; feed_en = 0; rand_full = 0;
    hold_addr = 16'h0; hold_we = 1'b0; hold_wdata = 8'h0;
    for (int i = 0; i < 65536; i++) resp_mem[i] = init_byte(16'(i));

    vec[0] = '{4, 32'h571234A5, 2, 0, 16'h0000, 8'h00, 1, 1, 16'h1234, 8'hA5, 2, 8'h06};
    vec[1] = '{3, 32'h5200FF00, 3, 1, 16'h00FF, 8'h3C, 1, 0, 16'h00FF, 8'h00, 3, 8'h3C};
    vec[2] = '{1, 32'h41000000, 1, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h15};
    vec[3] = '{3, 32'h52000100, 1, 1, 16'h0001, 8'h5A, 1, 0, 16'h0001, 8'h00, 1, 8'h5A};
    vec[4] = '{3, 32'h52123400, 1, 0, 16'h0000, 8'h00, 1, 0, 16'h1234, 8'h00, 1, 8'hA5};
    vec[5] = '{1, 32'h77000000, 1, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h15};
    vec[6] = '{4, 32'h57FFFF00, 4, 0, 16'h0000, 8'h00, 1, 1, 16'hFFFF, 8'h00, 4, 8'h06};

    // Reset values, with a byte waiting in the RX FIFO
    rx_q.push_back(8'h52);
    drive_rx();
    repeat (3) @(negedge clk);
    check("rst_rd_uart", 32'(rd_uart), 32'd0);
    check("rst_wr_uart", 32'(wr_uart), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_w_data", 32'(w_data), 32'd0);
    rx_q.delete();
    drive_rx();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Minimum latency: FIFO pre-loaded, ack in the first MEM cycle
    clear_logs();
    rx_q = '{8'h52, 8'h00, 8'hFF};
    drive_rx();
    ack_lat = 1;
    wr_at = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (tx_log.size() > 0 && wr_at == 0) wr_at = c;
    end
    check("min_latency_cycles", 32'(wr_at), 32'd5);
    check("min_latency_tx_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("min_latency_tx", 32'(tx_log[0]), 32'(init_byte(16'h00FF)));
    if (acc_log.size() > 0) check("min_latency_req_cycles", 32'(acc_log[0].cyc), 32'd1);

    // Directed vector table
    for (int k = 0; k < 7; k++) begin
      clear_logs();
      if (vec[k].pre_en) resp_mem[vec[k].pre_addr] = vec[k].pre_val;
      for (int i = 0; i < vec[k].nb; i++) rx_q.push_back(vec[k].b[31 - 8 * i -: 8]);
      ack_lat = vec[k].lat;
      drive_rx();
      run_until_tx(1, 80, ok);
      step();
      step();
      check($sformatf("v%0d_done", k), 32'(ok), 32'd1);
      check($sformatf("v%0d_tx_count", k), 32'(tx_log.size()), 32'd1);
      if (tx_log.size() > 0) check($sformatf("v%0d_tx", k), 32'(tx_log[0]), 32'(vec[k].exp_tx));
      check($sformatf("v%0d_acc_count", k), 32'(acc_log.size()), 32'(vec[k].exp_acc));
      if (vec[k].exp_acc && acc_log.size() > 0) begin
        check($sformatf("v%0d_we", k), 32'(acc_log[0].we), 32'(vec[k].exp_we));
        check($sformatf("v%0d_addr", k), 32'(acc_log[0].addr), 32'(vec[k].exp_addr));
        check($sformatf("v%0d_req_cycles", k), 32'(acc_log[0].cyc), 32'(vec[k].exp_cyc));
        if (vec[k].exp_we)
          check($sformatf("v%0d_wdata", k), 32'(acc_log[0].wdata), 32'(vec[k].exp_wdata));
      end
      check($sformatf("v%0d_idle", k), 32'(busy), 32'd0);
    end

    // Backpressure: TX FIFO full for 10 cycles while the response waits
    clear_logs();
    tx_full = 1'b1;
    ack_lat = 1;
    rx_q = '{8'h57, 8'h00, 8'h10, 8'h77};
    drive_rx();
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (acc_log.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_access_done", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_wr_held_low", 32'(wr_uart), 32'd0);
      check("bp_busy_held", 32'(busy), 32'd1);
      step();
    end
    tx_full = 1'b0;
    #1;
    check("bp_push_on_release", 32'(wr_uart), 32'd1);
    check("bp_busy_at_push", 32'(busy), 32'd1);
    check("bp_w_data", 32'(w_data), 32'h06);
    step();
    check("bp_idle_after_push", 32'(busy), 32'd0);
    repeat (3) step();
    check("bp_push_count", 32'(tx_log.size()), 32'd1);

    // Abort: reset while waiting in MEM, then a stray ack, then a clean read
    clear_logs();
    ack_lat = 1000;
    rx_q = '{8'h57, 8'hAB, 8'hCD, 8'h01};
    drive_rx();
    for (int i = 0; i < 20; i++) begin
      if (mem_req) break;
      step();
    end
    check("abort_in_mem", 32'(mem_req), 32'd1);
    step();
    step();
    reset = 1'b1;
    #1;
    check("abort_req_dropped", 32'(mem_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_uart", 32'(wr_uart), 32'd0);
    check("abort_addr_cleared", 32'(mem_addr), 32'd0);
    step();
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    ack_force = 1'b1;
    step();
    step();
    ack_force = 1'b0;
    mem_ack = 1'b0;
    check("abort_stray_ack_busy", 32'(busy), 32'd0);
    check("abort_stray_ack_req", 32'(mem_req), 32'd0);
    check("abort_no_access", 32'(acc_log.size()), 32'd0);
    check("abort_no_tx", 32'(tx_log.size()), 32'd0);
    ack_lat = 2;
    rx_q = '{8'h52, 8'hAB, 8'hCD};
    drive_rx();
    run_until_tx(1, 80, ok);
    check("abort_read_done", 32'(ok), 32'd1);
    if (tx_log.size() > 0) check("abort_read_tx", 32'(tx_log[0]), 32'(init_byte(16'hABCD)));
    if (acc_log.size() > 0) begin
      check("abort_read_addr", 32'(acc_log[0].addr), 32'hABCD);
      check("abort_read_we", 32'(acc_log[0].we), 32'd0);
    end

    // Randomized command stream against a transaction-level model
    repeat (3) step();
    clear_logs();
    for (int i = 0; i < 65536; i++) model_mem[i] = resp_mem[i];
    exp_acc.delete();
    exp_tx.delete();
    for (int c = 0; c < 40; c++) begin
      kind = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      d = 8'($urandom);
      if (kind < 5) begin
        pend_q.push_back(8'h57); pend_q.push_back(a[15:8]);
        pend_q.push_back(a[7:0]); pend_q.push_back(d);
        exp_acc.push_back('{we: 1'b1, addr: a, wdata: d, cyc: 0});
        model_mem[a] = d;
        exp_tx.push_back(8'h06);
      end else if (kind < 9) begin
        pend_q.push_back(8'h52); pend_q.push_back(a[15:8]); pend_q.push_back(a[7:0]);
        exp_acc.push_back('{we: 1'b0, addr: a, wdata: 8'h00, cyc: 0});
        exp_tx.push_back(model_mem[a]);
      end else begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
        pend_q.push_back(op);
        exp_tx.push_back(8'h15);
      end
    end
    rand_lat = 1; spur_en = 1; rand_full = 1; feed_en = 1;
    run_until_tx(exp_tx.size(), 4000, ok);
    rand_lat = 0; spur_en = 0; rand_full = 0; feed_en = 0;
    tx_full = 1'b0;
    mem_ack = 1'b0;
    repeat (5) step();
    check("rand_done", 32'(ok), 32'd1);
    check("rand_tx_count", 32'(tx_log.size()), 32'(exp_tx.size()));
    check("rand_acc_count", 32'(acc_log.size()), 32'(exp_acc.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      check($sformatf("rand_tx%0d", i), 32'(tx_log[i]), 32'(exp_tx[i]));
    for (int i = 0; i < exp_acc.size() && i < acc_log.size(); i++) begin
      check($sformatf("rand_acc%0d_we", i), 32'(acc_log[i].we), 32'(exp_acc[i].we));
      check($sformatf("rand_acc%0d_addr", i), 32'(acc_log[i].addr), 32'(exp_acc[i].addr));
      if (exp_acc[i].we)
        check($sformatf("rand_acc%0d_wdata", i), 32'(acc_log[i].wdata), 32'(exp_acc[i].wdata));
    end
    check("rand_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: run still active at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
